// File: rtl/fixed_point_long_divider_unsigned.sv
// Unsigned Q-format restoring long divider, one quotient bit per clock.
// Valid/ready on both sides; saturates on overflow and flags divide-by-zero.
module fixed_point_long_divider_unsigned #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_div_by_zero,
  output logic              o_overflow
);

  localparam int N  = DATA_W + FRAC_W;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]     cnt;
  logic [N-1:0]      num;
  logic [N-1:0]      num_in;
  logic [N-1:0]      quo;
  logic [N-1:0]      quo_nx;
  logic [DATA_W:0]   rem;
  logic [DATA_W:0]   rsh;
  logic [DATA_W:0]   rem_nx;
  logic [DATA_W-1:0] div;
  logic              qbit;
  logic              last;
  logic              accept;
  logic              out_hs;
  logic              ovf;
  logic              dz;

  assign accept = i_valid && o_ready;
  assign out_hs = o_valid && i_ready;
  assign last   = (cnt == CW'(N - 1));
  assign dz     = (i_divisor == '0);
  assign num_in = N'(i_dividend) << FRAC_W;

  // Partial remainder stays below div, so DATA_W+1 bits hold r'.
  always_comb begin
    rsh    = {rem[DATA_W-1:0], num[N-1]};
    qbit   = (rsh >= {1'b0, div});
    rem_nx = qbit ? (rsh - {1'b0, div}) : rsh;
    quo_nx = {quo[N-2:0], qbit};
    ovf    = |(quo_nx >> DATA_W);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = dz ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_hs) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt           <= '0;
      num           <= '0;
      quo           <= '0;
      rem           <= '0;
      div           <= '0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
      o_overflow    <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && dz) begin
        o_quotient    <= '1;
        o_remainder   <= i_dividend;
        o_div_by_zero <= 1'b1;
        o_overflow    <= 1'b0;
      end else if (accept) begin
        num <= num_in;
        div <= i_divisor;
        rem <= '0;
        quo <= '0;
        cnt <= '0;
      end
    end else if (state == BUSY) begin
      num <= num << 1;
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        o_quotient    <= ovf ? '1 : quo_nx[DATA_W-1:0];
        o_remainder   <= rem_nx[DATA_W-1:0];
        o_div_by_zero <= 1'b0;
        o_overflow    <= ovf;
      end
    end
  end

endmodule
